// File: rtl/axis_frame_sink_pkg.sv
// Shared types and constants for the axis_frame_sink block.
//   state_e      : frame FSM states
//   status_rec_t : per-frame status record (len, err, oversize, cksum)
//   CKSUM_WIDTH  : width of the wrapping byte checksum
// The record's len field is sized for the widest supported LEN_WIDTH (32);
// each instance zero-extends its counter into it.
package axis_frame_sink_pkg;

    localparam int unsigned CKSUM_WIDTH     = 16;
    localparam int unsigned LEN_FIELD_WIDTH = 32;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StStatus
    } state_e;

    typedef struct packed {
        logic [LEN_FIELD_WIDTH-1:0] len;
        logic                       err;
        logic                       oversize;
        logic [CKSUM_WIDTH-1:0]     cksum;
    } status_rec_t;

endpackage

// File: rtl/axis_frame_sink_acc.sv
// Per-frame accumulator: beat count, sticky error flag and optional checksum.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : first beat of a frame (restart with len=1)
//   accumulate  : subsequent beat of the frame
//   clear       : drop the record (status taken)
//   data, user  : beat payload and error flag
//   rec         : current status record
// Build option: AXIS_FRAME_SINK_CKSUM_EN builds the checksum adder;
// without it rec.cksum is tied to 0.
module axis_frame_sink_acc
    import axis_frame_sink_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned MAX_LEN    = 1518
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  accumulate,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  user,
    output status_rec_t           rec
);

    logic [LEN_WIDTH-1:0]   len_q;
    logic                   ovf_q;
    logic                   err_q;
    logic [CKSUM_WIDTH-1:0] cksum;

    // ovf_q remembers that the counter saturated and a further beat arrived,
    // so oversize stays set even though len_q no longer grows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else if (clear) begin
            len_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else if (load) begin
            len_q <= LEN_WIDTH'(1);
            ovf_q <= 1'b0;
            err_q <= user;
        end else if (accumulate) begin
            if (len_q == '1) begin
                ovf_q <= 1'b1;
            end else begin
                len_q <= len_q + LEN_WIDTH'(1);
            end
            err_q <= err_q | user;
        end
    end

`ifdef AXIS_FRAME_SINK_CKSUM_EN
    logic [CKSUM_WIDTH-1:0] cksum_q;
    logic [CKSUM_WIDTH-1:0] data_ext;

    assign data_ext = CKSUM_WIDTH'(data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cksum_q <= '0;
        end else if (clear) begin
            cksum_q <= '0;
        end else if (load) begin
            cksum_q <= data_ext;
        end else if (accumulate) begin
            cksum_q <= cksum_q + data_ext;
        end
    end

    assign cksum = cksum_q;
`else
    logic unused_data;
    assign unused_data = ^data;
    assign cksum       = '0;
`endif

    assign rec = '{
        len:      LEN_FIELD_WIDTH'(len_q),
        err:      err_q,
        oversize: ovf_q | (LEN_FIELD_WIDTH'(len_q) > LEN_FIELD_WIDTH'(MAX_LEN)),
        cksum:    cksum
    };

endmodule

// File: rtl/axis_frame_sink.sv
// AXI-stream frame sink: counts beats per frame, records the error flag and
// an optional byte checksum, and offers one status record per frame on a
// valid/ready port. The stream is stalled while a record is pending.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   input_axis_*       : incoming stream (tdata/tvalid/tready/tlast/tuser)
//   status_valid/ready : status record handshake
//   status_len/err/oversize/cksum : record fields, stable while status_valid
//   frame_count        : frames whose status was taken since reset
// Build option: AXIS_FRAME_SINK_CKSUM_EN enables the checksum; otherwise
// status_cksum reads 0.
module axis_frame_sink
    import axis_frame_sink_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned MAX_LEN    = 1518,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  input_axis_tdata,
    input  logic                   input_axis_tvalid,
    output logic                   input_axis_tready,
    input  logic                   input_axis_tlast,
    input  logic                   input_axis_tuser,
    output logic                   status_valid,
    input  logic                   status_ready,
    output logic [LEN_WIDTH-1:0]   status_len,
    output logic                   status_err,
    output logic                   status_oversize,
    output logic [CKSUM_WIDTH-1:0] status_cksum,
    output logic [CNT_WIDTH-1:0]   frame_count
);

    state_e                state_q;
    logic                  tready_q;
    logic                  status_valid_q;
    logic [CNT_WIDTH-1:0]  frame_count_q;
    logic                  beat_accept;
    logic                  status_take;
    status_rec_t           rec;

    assign beat_accept = input_axis_tvalid & tready_q;
    assign status_take = status_valid_q & status_ready;

    // tready is registered: it stays low through reset and rises on the first
    // edge after release, and it drops on the edge that accepts tlast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            tready_q       <= 1'b0;
            status_valid_q <= 1'b0;
            frame_count_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle, StActive: begin
                    tready_q <= 1'b1;
                    if (beat_accept) begin
                        if (input_axis_tlast) begin
                            state_q        <= StStatus;
                            tready_q       <= 1'b0;
                            status_valid_q <= 1'b1;
                        end else begin
                            state_q <= StActive;
                        end
                    end
                end
                StStatus: begin
                    if (status_take) begin
                        state_q        <= StIdle;
                        tready_q       <= 1'b1;
                        status_valid_q <= 1'b0;
                        frame_count_q  <= frame_count_q + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_q        <= StIdle;
                    tready_q       <= 1'b0;
                    status_valid_q <= 1'b0;
                end
            endcase
        end
    end

    axis_frame_sink_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .MAX_LEN    (MAX_LEN)
    ) u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (beat_accept && (state_q == StIdle)),
        .accumulate (beat_accept && (state_q == StActive)),
        .clear      (status_take),
        .data       (input_axis_tdata),
        .user       (input_axis_tuser),
        .rec        (rec)
    );

    // Upper record bits are always zero for this instance's LEN_WIDTH.
    logic unused_len_hi;
    assign unused_len_hi = ^(rec.len >> LEN_WIDTH);

    assign input_axis_tready = tready_q;
    assign status_valid      = status_valid_q;
    assign status_len        = rec.len[LEN_WIDTH-1:0];
    assign status_err        = rec.err;
    assign status_oversize   = rec.oversize;
    assign status_cksum      = rec.cksum;
    assign frame_count       = frame_count_q;

endmodule

// File: tb/tb_axis_frame_sink.sv
// Scoreboard bench for axis_frame_sink (LEN_WIDTH=3, MAX_LEN=4).
module tb_axis_frame_sink;

    localparam int unsigned DW = 8;
    localparam int unsigned LW = 3;
    localparam int unsigned ML = 4;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          tuser;
    logic          status_valid;
    logic          status_ready;
    logic [LW-1:0] status_len;
    logic          status_err;
    logic          status_oversize;
    logic [15:0]   status_cksum;
    logic [CW-1:0] frame_count;

    always #5 clk = ~clk;

    axis_frame_sink #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .MAX_LEN    (ML),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .input_axis_tdata  (tdata),
        .input_axis_tvalid (tvalid),
        .input_axis_tready (tready),
        .input_axis_tlast  (tlast),
        .input_axis_tuser  (tuser),
        .status_valid      (status_valid),
        .status_ready      (status_ready),
        .status_len        (status_len),
        .status_err        (status_err),
        .status_oversize   (status_oversize),
        .status_cksum      (status_cksum),
        .frame_count       (frame_count)
    );

    typedef struct {
        int unsigned len;
        bit          err;
        bit          ovs;
        int unsigned cksum;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_exp(input int unsigned len, input bit err, input bit ovs,
                            input int unsigned cksum);
        exp_t e;
        e.len = len;
        e.err = err;
        e.ovs = ovs;
`ifdef AXIS_FRAME_SINK_CKSUM_EN
        e.cksum = cksum;
`else
        e.cksum = (cksum == 32'hFFFF_FFFF) ? 1 : 0;
`endif
        sb.push_back(e);
    endtask

    // Call at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l);
        int w = 0;
        tdata  = d;
        tuser  = u;
        tlast  = l;
        tvalid = 1'b1;
        do begin
            @(negedge clk);
            w++;
        end while (!tready && w < 50);
        if (!tready) check("beat_accept_timeout", 32'(tready), 32'd1);
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [DW-1:0] base, input int err_beat);
        for (int i = 0; i < n; i++) begin
            send_beat(base + DW'(i), (i == err_beat), (i == n - 1));
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Returns at a negedge once status_valid is low again.
    task automatic wait_drain();
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (status_valid && w < 50);
        check("status_drain", 32'(status_valid), 32'd0);
    endtask

    // Monitor: pop and compare on every status handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && status_valid && status_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_status", 32'(status_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("status_len", 32'(status_len), e.len);
                check("status_err", 32'(status_err), 32'(e.err));
                check("status_oversize", 32'(status_oversize), 32'(e.ovs));
                check("status_cksum", 32'(status_cksum), e.cksum);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        tvalid       = 1'b0;
        tdata        = '0;
        tlast        = 1'b0;
        tuser        = 1'b0;
        status_ready = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tready", 32'(tready), 32'd0);
        check("rst_status_valid", 32'(status_valid), 32'd0);
        check("rst_len", 32'(status_len), 32'd0);
        check("rst_err", 32'(status_err), 32'd0);
        check("rst_oversize", 32'(status_oversize), 32'd0);
        check("rst_cksum", 32'(status_cksum), 32'd0);
        check("rst_frame_count", frame_count, 32'd0);
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        check("tready_at_release", 32'(tready), 32'd0);
        @(negedge clk);
        check("tready_after_release", 32'(tready), 32'd1);
        sync();

        // Basic 4-beat frame: 1+2+3+4 = 0x0A.
        status_ready = 1'b1;
        push_exp(4, 0, 0, 32'h000A);
        send_frame(4, 8'h01, -1);
        @(negedge clk);
        check("basic_status_valid", 32'(status_valid), 32'd1);
        check("basic_tready_low", 32'(tready), 32'd0);
        sync();
        @(negedge clk);
        check("basic_frame_count", frame_count, 32'd1);
        check("basic_valid_dropped", 32'(status_valid), 32'd0);
        check("basic_tready_back", 32'(tready), 32'd1);
        sync();

        // Backpressure: lone tlast beat, status held for 5 cycles.
        status_ready = 1'b0;
        push_exp(1, 0, 0, 32'h00FF);
        send_beat(8'hFF, 1'b0, 1'b1);
        tdata  = 8'h11;
        tuser  = 1'b0;
        tlast  = 1'b0;
        tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_tready", 32'(tready), 32'd0);
            check("bp_valid", 32'(status_valid), 32'd1);
            check("bp_len", 32'(status_len), 32'd1);
`ifdef AXIS_FRAME_SINK_CKSUM_EN
            check("bp_cksum", 32'(status_cksum), 32'h00FF);
`else
            check("bp_cksum", 32'(status_cksum), 32'h0000);
`endif
        end
        sync();
        status_ready = 1'b1;
        @(negedge clk);
        check("bp_handshake_tready", 32'(tready), 32'd0);
        sync();
        @(negedge clk);
        check("bp_tready_after_hs", 32'(tready), 32'd1);
        check("bp_frame_count", frame_count, 32'd2);
        // Held beat 0x11 is accepted on this edge; 0x11+0x22 = 0x33.
        push_exp(2, 0, 0, 32'h0033);
        sync();
        send_beat(8'h22, 1'b0, 1'b1);
        wait_drain();
        sync();

        // Error on beat 3 of 6, above MAX_LEN: 1+..+6 = 0x15.
        push_exp(6, 1, 1, 32'h0015);
        send_frame(6, 8'h01, 2);
        wait_drain();
        sync();

        // One beat past MAX_LEN: 0x10..0x14 = 0x5A.
        push_exp(5, 0, 1, 32'h005A);
        send_frame(5, 8'h10, -1);
        wait_drain();
        sync();

        // Saturation: 10 beats 0xF0..0xF9 = 0x98D, len stuck at 7.
        push_exp(7, 0, 1, 32'h098D);
        send_frame(10, 8'hF0, -1);
        wait_drain();
        sync();

        // Counter restarts cleanly: 0x80+0x81 = 0x101.
        push_exp(2, 0, 0, 32'h0101);
        send_frame(2, 8'h80, -1);
        wait_drain();
        check("frame_count_before_reset", frame_count, 32'd7);
        sync();

        // Reset mid-frame.
        send_beat(8'h40, 1'b0, 1'b0);
        send_beat(8'h41, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_frame_count", frame_count, 32'd0);
        check("midrst_valid", 32'(status_valid), 32'd0);
        check("midrst_len", 32'(status_len), 32'd0);
        check("midrst_tready", 32'(tready), 32'd0);
        sync();
        rst_n = 1'b1;
        push_exp(3, 0, 0, 32'h0012);
        send_frame(3, 8'h05, -1);
        wait_drain();
        check("post_reset_frame_count", frame_count, 32'd1);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
